// File: rtl/util_fifo2pkt.sv
// Store-and-forward packetiser: buffers 64-bit words in a register FIFO and
// emits whole packets of pkt_len words on an Avalon-ST source with sop/eop.
module util_fifo2pkt #(
    parameter int AW = 4,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [63:0]   wr_data,
    input  logic [LW-1:0] pkt_len,
    input  logic          src_ready,
    output logic          src_valid,
    output logic [63:0]   src_data,
    output logic          src_sop,
    output logic          src_eop,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          overflow_clr
);

    localparam int DEPTH = 2 ** AW;
    // Common width so level and pkt_len compare without truncating either.
    localparam int CW = ((AW + 1) > LW) ? (AW + 1) : LW;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [0:0]    state_q, state_d;
    logic          overflow_q, overflow_d;

    logic          full;
    logic          rd_evt;
    logic          wr_acc;
    logic          wr_drop;
    logic [CW-1:0] level_ext;
    logic [CW-1:0] level_m1_ext;
    logic [CW-1:0] pkt_len_ext;
    logic          start_ok;
    logic          next_ok;

    assign full    = (level_q == (AW + 1)'(DEPTH));
    assign rd_evt  = src_valid & src_ready;
    // A pop in the same cycle frees the slot the write lands in.
    assign wr_acc  = wr_en & (~full | rd_evt);
    assign wr_drop = wr_en & full & ~rd_evt;

    assign level_ext    = CW'(level_q);
    assign level_m1_ext = CW'(level_q) - CW'(1);
    assign pkt_len_ext  = CW'(pkt_len);
    assign start_ok     = (pkt_len != '0) && (level_ext >= pkt_len_ext);
    // Only evaluated on the last beat of a packet, where level_q >= 1.
    assign next_ok      = (pkt_len != '0) && (level_m1_ext >= pkt_len_ext);

    always_comb begin
        wr_ptr_d   = wr_acc ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d   = rd_evt ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        level_d    = level_q + (AW + 1)'(wr_acc) - (AW + 1)'(rd_evt);
        overflow_d = overflow_q;
        if (overflow_clr) begin
            overflow_d = 1'b0;
        end else if (wr_drop) begin
            overflow_d = 1'b1;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                len_d = pkt_len;
                if (start_ok) begin
                    state_d = S_SEND;
                    cnt_d   = LW'(1);
                end
            end
            S_SEND: begin
                if (rd_evt) begin
                    if (cnt_q < len_q) begin
                        cnt_d = cnt_q + LW'(1);
                    end else if (next_ok) begin
                        len_d = pkt_len;
                        cnt_d = LW'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            state_q    <= S_IDLE;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is data only; stale contents are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign src_valid = (state_q == S_SEND);
    assign src_data  = src_valid ? mem_q[rd_ptr_q] : 64'd0;
    assign src_sop   = src_valid && (cnt_q == LW'(1));
    assign src_eop   = src_valid && (cnt_q == len_q);
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_util_fifo2pkt.sv
// Directed bench for util_fifo2pkt: packet framing, back-pressure,
// back-to-back packets, overflow handling and reset truncation.
module tb_util_fifo2pkt;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [63:0] wr_data;
    logic [7:0]  pkt_len;
    logic        src_ready;
    logic        src_valid;
    logic [63:0] src_data;
    logic        src_sop;
    logic        src_eop;
    logic [4:0]  level;
    logic        overflow;
    logic        overflow_clr;

    int checks   = 0;
    int failures = 0;

    util_fifo2pkt #(.AW(4), .LW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .pkt_len      (pkt_len),
        .src_ready    (src_ready),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_sop      (src_sop),
        .src_eop      (src_eop),
        .level        (level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] wa(input int i);
        return 64'hA000_0000_0000_0000 | 64'(i);
    endfunction
    function automatic logic [63:0] wb(input int i);
        return 64'hB000_0000_0000_0000 | 64'(i);
    endfunction
    function automatic logic [63:0] wc(input int i);
        return 64'hC000_0000_0000_0000 | 64'(i);
    endfunction
    function automatic logic [63:0] wd(input int i);
        return 64'hD000_0000_0000_0000 | 64'(i);
    endfunction
    function automatic logic [63:0] we(input int i);
        return 64'hE000_0000_0000_0000 | 64'(i);
    endfunction

    initial begin
        logic [3:0] rdy_pat;
        int idx;

        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; pkt_len = '0;
        src_ready = 1'b0; overflow_clr = 1'b0;
        cyc(); cyc();
        chk("rst_valid", 64'(src_valid), 64'd0);
        chk("rst_data", src_data, 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        cyc();

        // T2: basic 4-word packet
        pkt_len = 8'd4; src_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = wa(i);
            cyc();
        end
        wr_en = 1'b0;
        chk("t2_level4", 64'(level), 64'd4);
        chk("t2_idle_valid", 64'(src_valid), 64'd0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("t2_valid", 64'(src_valid), 64'd1);
            chk("t2_data", src_data, wa(i));
            chk("t2_sop", 64'(src_sop), 64'(i == 0));
            chk("t2_eop", 64'(src_eop), 64'(i == 3));
            if (i == 2) chk("t2_level_mid", 64'(level), 64'd2);
            cyc();
        end
        chk("t2_end_valid", 64'(src_valid), 64'd0);
        chk("t2_end_level", 64'(level), 64'd0);
        chk("t2_end_data", src_data, 64'd0);
        chk("t2_end_eop", 64'(src_eop), 64'd0);

        // T3: back-pressure with ready pattern 1,0,1,0,1
        pkt_len = 8'd3; src_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = wb(i);
            cyc();
        end
        wr_en = 1'b0;
        cyc();
        rdy_pat = 4'b0101;
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            src_ready = (k < 4) ? rdy_pat[k] : 1'b1;
            chk("t3_valid", 64'(src_valid), 64'd1);
            chk("t3_data", src_data, wb(idx));
            chk("t3_sop", 64'(src_sop), 64'(idx == 0));
            chk("t3_eop", 64'(src_eop), 64'(idx == 2));
            cyc();
            if (src_ready) idx++;
        end
        chk("t3_transfers", 64'(idx), 64'd3);
        chk("t3_end_valid", 64'(src_valid), 64'd0);
        chk("t3_end_level", 64'(level), 64'd0);

        // T4: six-word burst, three back-to-back 2-word packets
        pkt_len = 8'd2; src_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            wr_en = (k < 6); wr_data = wc(k);
            cyc();
            if ((k + 1) >= 3 && (k + 1) <= 8) begin
                chk("t4_valid", 64'(src_valid), 64'd1);
                chk("t4_data", src_data, wc(k - 2));
                chk("t4_sop", 64'(src_sop), 64'(((k - 2) % 2) == 0));
                chk("t4_eop", 64'(src_eop), 64'(((k - 2) % 2) == 1));
            end else begin
                chk("t4_gap_valid", 64'(src_valid), 64'd0);
            end
        end
        chk("t4_end_level", 64'(level), 64'd0);

        // T1: reset in the middle of a packet, then a fresh packet
        pkt_len = 8'd4; src_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = we(i);
            cyc();
        end
        wr_en = 1'b0;
        cyc();
        chk("t1_send_valid", 64'(src_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_valid", 64'(src_valid), 64'd0);
        chk("t1_rst_level", 64'(level), 64'd0);
        chk("t1_rst_ovf", 64'(overflow), 64'd0);
        chk("t1_rst_sop", 64'(src_sop), 64'd0);
        chk("t1_rst_data", src_data, 64'd0);
        cyc();
        rst_n = 1'b1;
        src_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = wa(10 + i);
            cyc();
            chk("t1_no_early_valid", 64'(src_valid), 64'd0);
        end
        wr_en = 1'b0;
        cyc();
        chk("t1_first_valid", 64'(src_valid), 64'd1);
        chk("t1_first_sop", 64'(src_sop), 64'd1);
        chk("t1_first_data", src_data, wa(10));
        cyc(); cyc(); cyc();
        chk("t1_last_data", src_data, wa(13));
        chk("t1_last_eop", 64'(src_eop), 64'd1);
        cyc();
        chk("t1_end_valid", 64'(src_valid), 64'd0);
        chk("t1_end_level", 64'(level), 64'd0);

        // Re-align pointers to zero before the overflow tests
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        // T5: overflow with no reads
        pkt_len = 8'd20; src_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = wd(i);
            cyc();
        end
        chk("t5_level16", 64'(level), 64'd16);
        chk("t5_no_ovf_yet", 64'(overflow), 64'd0);
        wr_data = wd(16);
        cyc();
        chk("t5_level_stays", 64'(level), 64'd16);
        chk("t5_ovf_set", 64'(overflow), 64'd1);
        chk("t5_no_start", 64'(src_valid), 64'd0);
        wr_en = 1'b0; overflow_clr = 1'b1;
        cyc();
        chk("t5_ovf_clr", 64'(overflow), 64'd0);
        overflow_clr = 1'b0; wr_en = 1'b1; wr_data = wd(17);
        cyc();
        chk("t5_ovf_again", 64'(overflow), 64'd1);
        overflow_clr = 1'b1; wr_data = wd(18);
        cyc();
        chk("t5_clr_priority", 64'(overflow), 64'd0);
        chk("t5_level_final", 64'(level), 64'd16);
        wr_en = 1'b0; overflow_clr = 1'b0;

        // T6: pop and write in the same cycle while full
        pkt_len = 8'd16;
        cyc();
        chk("t6_send", 64'(src_valid), 64'd1);
        chk("t6_d0", src_data, wd(0));
        chk("t6_sop", 64'(src_sop), 64'd1);
        src_ready = 1'b1; wr_en = 1'b1; wr_data = 64'hF00D_F00D_F00D_F00D;
        cyc();
        wr_en = 1'b0;
        chk("t6_level16", 64'(level), 64'd16);
        chk("t6_no_ovf", 64'(overflow), 64'd0);
        for (int j = 1; j < 16; j++) begin
            chk("t6_data", src_data, wd(j));
            chk("t6_sop_low", 64'(src_sop), 64'd0);
            chk("t6_eop", 64'(src_eop), 64'(j == 15));
            cyc();
        end
        chk("t6_idle", 64'(src_valid), 64'd0);
        chk("t6_level1", 64'(level), 64'd1);
        pkt_len = 8'd1;
        cyc();
        chk("t6_wrap_valid", 64'(src_valid), 64'd1);
        chk("t6_wrap_data", src_data, 64'hF00D_F00D_F00D_F00D);
        chk("t6_wrap_sop", 64'(src_sop), 64'd1);
        chk("t6_wrap_eop", 64'(src_eop), 64'd1);
        cyc();
        chk("t6_end_valid", 64'(src_valid), 64'd0);
        chk("t6_end_level", 64'(level), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
